sm3_hash_store: RTL and testbench



---
 rtl/sm3_pkg.sv | 8 +
 rtl/sm3_word_sel.sv | 16 +
 rtl/sm3_hash_store.sv | 76 +++++++
 tb/tb_sm3_hash_store.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pkg.sv
// sm3_pkg: shared SM3 types and constants for the accelerator blocks
package sm3_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  localparam int SM3_WORDS = 8;
  localparam int SM3_DIGEST_W = 256;
  localparam logic [SM3_DIGEST_W-1:0] SM3_IV =
    256'h7380166f_4914b2b9_172442d7_da8a0600_a96f30bc_163138aa_e38dee4d_b0fb0e4e;
endpackage

// File: rtl/sm3_word_sel.sv
// sm3_word_sel: 8:1 digest word mux, word 0 = bits [255:224]; byte-reversed when SM3_STORE_BYTESWAP_EN is defined
module sm3_word_sel
  import sm3_pkg::*;
(
  input  logic [SM3_DIGEST_W-1:0] digest,
  input  logic [2:0]              sel,
  output logic [31:0]             word
);
  logic [31:0] raw;
  assign raw = digest[{~sel, 5'd0} +: 32];
`ifdef SM3_STORE_BYTESWAP_EN
  assign word = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]};
`else
  assign word = raw;
`endif
endmodule

// File: rtl/sm3_hash_store.sv
// sm3_hash_store: captures the SM3 digest on a save_hash rise and stores it as eight words; optional SM3_STORE_BYTESWAP_EN
module sm3_hash_store
  import sm3_pkg::*;
#(
  parameter int WORDS = SM3_WORDS,
  parameter int AW = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    save_hash,
  input  logic [SM3_DIGEST_W-1:0] hash_value,
  input  logic [AW-1:0]           dst_addr,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ready,
  output logic                    hold_pipeline,
  output logic                    busy,
  output logic                    done
);
  state_t                  state, state_nx;
  logic                    save_hash_q;
  logic [SM3_DIGEST_W-1:0] digest_q;
  logic [AW-1:0]           base;
  logic [2:0]              cnt;
  logic                    cap, accept, last;

  assign cap = save_hash & ~save_hash_q & (state == IDLE);
  assign accept = mem_req & mem_ready;
  assign last = cnt == 3'(WORDS - 1);
  assign mem_req = state == WRITE;
  assign mem_we = mem_req;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign hold_pipeline = cap | mem_req | done;
  assign mem_addr = base + AW'({cnt, 2'b00});

  sm3_word_sel u_sel (
    .digest(digest_q),
    .sel(cnt),
    .word(mem_wdata)
  );

  // delayed copy of the flag for rising-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) save_hash_q <= 1'b0;
    else save_hash_q <= save_hash;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  // next state: capture, walk the words, one-cycle done
  always_comb begin
    state_nx = state;
    if (cap) state_nx = WRITE;
    else if (state == WRITE && accept && last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end

  // digest, base address and word counter; counter only moves on accept
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      digest_q <= '0;
      base <= '0;
      cnt <= '0;
    end else if (cap) begin
      digest_q <= hash_value;
      base <= {dst_addr[AW-1:2], 2'b00};
      cnt <= '0;
    end else if (accept && !last) begin
      cnt <= cnt + 3'd1;
    end
endmodule

// File: tb/tb_sm3_hash_store.sv
// tb_sm3_hash_store: randomized self-checking bench against a behavioural store model
module tb_sm3_hash_store;
  logic clk = 0, rst = 1, save_hash = 0, mem_ready = 1;
  logic [255:0] hash_value = '0;
  logic [31:0] dst_addr = '0;
  logic mem_req, mem_we, hold_pipeline, busy, done;
  logic [31:0] mem_addr, mem_wdata;
  int vectors = 0, errs = 0, cyc = 0, t0 = 0;
  bit logging = 0;

  typedef struct {
    int r;
    logic req, we, rdy, done, hold, busy;
    logic [31:0] addr, data;
  } ent_t;
  ent_t log_q[$];

  localparam logic [255:0] ABC =
    256'h66c7f0f4_62eeedd9_d1f2d46b_dc10e4e2_4167c487_5cf2f7a2_297da02b_8f4ba8e0;
`ifdef SM3_STORE_BYTESWAP_EN
  localparam logic [31:0] W0 = 32'hf4f0c766, W1 = 32'hd9edee62, W7 = 32'he0a84b8f;
`else
  localparam logic [31:0] W0 = 32'h66c7f0f4, W1 = 32'h62eeedd9, W7 = 32'h8f4ba8e0;
`endif

  sm3_hash_store dut (
    .clk(clk), .rst(rst), .save_hash(save_hash), .hash_value(hash_value),
    .dst_addr(dst_addr), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .hold_pipeline(hold_pipeline),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (logging) begin
      ent_t e;
      e.r = cyc - t0;
      e.req = mem_req; e.we = mem_we; e.rdy = mem_ready; e.done = done;
      e.hold = hold_pipeline; e.busy = busy; e.addr = mem_addr; e.data = mem_wdata;
      log_q.push_back(e);
    end

  function automatic logic [31:0] exp_word(input logic [255:0] d, input int i);
    logic [31:0] w = 32'(d >> (32 * (7 - i)));
`ifdef SM3_STORE_BYTESWAP_EN
    w = {<<8{w}};
`endif
    return w;
  endfunction

  function automatic logic [255:0] rand_digest();
    logic [255:0] d = '0;
    for (int i = 0; i < 8; i++) d = {d[223:0], 32'($urandom)};
    return d;
  endfunction

  task automatic drive_transfer(input logic [255:0] d, input logic [31:0] a,
                                input logic [63:0] smask, input logic [63:0] lmask, input int ncyc);
    log_q.delete();
    @(posedge clk); #1;
    t0 = cyc; logging = 1; hash_value = d; dst_addr = a;
    for (int r = 0; r < ncyc; r++) begin
      if (r > 0) begin
        @(posedge clk); #1;
        hash_value = rand_digest(); dst_addr = $urandom;
      end
      save_hash = smask[r]; mem_ready = !lmask[r];
    end
    @(negedge clk);
    logging = 0; save_hash = 0; mem_ready = 1;
  endtask

  task automatic test_store(input string name, input logic [255:0] d, input logic [31:0] a,
                            input logic [63:0] smask, input logic [63:0] lmask);
    int acc_r[8];
    int r = 1, n = 0, ndone = 0, dr = -1, done_r;
    logic [31:0] ea;
    for (int i = 0; i < 8; i++) begin
      while (lmask[r]) r++;
      acc_r[i] = r;
      r++;
    end
    done_r = acc_r[7] + 1;
    drive_transfer(d, a, smask, lmask, done_r + 3);
    foreach (log_q[j]) begin
      if (log_q[j].req && log_q[j].rdy) begin
        if (n < 8) begin
          ea = (a & ~32'h3) + 32'(4 * n);
          vectors++;
          if (log_q[j].r !== acc_r[n] || log_q[j].addr !== ea || log_q[j].data !== exp_word(d, n) || log_q[j].we !== 1'b1) begin
            errs++;
            $display("FAIL %s word%0d: cycle %0d addr %h data %h we %b, required cycle %0d addr %h data %h we 1",
                     name, n, log_q[j].r, log_q[j].addr, log_q[j].data, log_q[j].we, acc_r[n], ea, exp_word(d, n));
          end
        end
        n++;
      end
      if (log_q[j].req && !log_q[j].rdy && j + 1 < log_q.size()) begin
        vectors++;
        if (log_q[j + 1].req !== 1'b1 || log_q[j + 1].addr !== log_q[j].addr || log_q[j + 1].data !== log_q[j].data) begin
          errs++;
          $display("FAIL %s stable cycle %0d: req %b addr %h data %h, required req 1 addr %h data %h",
                   name, j + 1, log_q[j + 1].req, log_q[j + 1].addr, log_q[j + 1].data, log_q[j].addr, log_q[j].data);
        end
      end
      if (log_q[j].done) begin
        ndone++;
        dr = log_q[j].r;
      end
      vectors++;
      if (log_q[j].hold !== (j <= done_r) || log_q[j].busy !== (j >= 1 && j <= done_r)) begin
        errs++;
        $display("FAIL %s hold/busy cycle %0d: %b/%b, required %b/%b",
                 name, j, log_q[j].hold, log_q[j].busy, j <= done_r, j >= 1 && j <= done_r);
      end
    end
    vectors++;
    if (n !== 8) begin
      errs++;
      $display("FAIL %s store count: %0d, required 8", name, n);
    end
    vectors++;
    if (ndone !== 1 || dr !== done_r) begin
      errs++;
      $display("FAIL %s done: %0d pulses last at cycle %0d, required 1 at cycle %0d", name, ndone, dr, done_r);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, hold_pipeline, busy, done} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errs++;
      $display("FAIL reset: req/we/hold/busy/done %b addr %h data %h, required all 0",
               {mem_req, mem_we, hold_pipeline, busy, done}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    vectors++;
    if ({mem_req, hold_pipeline, busy, done} !== 4'b0) begin
      errs++;
      $display("FAIL reset release: req/hold/busy/done %b, required 0000", {mem_req, hold_pipeline, busy, done});
    end
  endtask

  task automatic test_abc;
    test_store("abc", ABC, 32'h1000, '1, '0);
    vectors++;
    if (log_q[1].addr !== 32'h1000 || log_q[1].data !== W0 || log_q[8].addr !== 32'h101c ||
        log_q[8].data !== W7 || log_q[9].done !== 1'b1 || log_q[10].hold !== 1'b0) begin
      errs++;
      $display("FAIL abc literal: w0 %h@%h w7 %h@%h done9 %b hold10 %b, required %h@00001000 %h@0000101c 1 0",
               log_q[1].data, log_q[1].addr, log_q[8].data, log_q[8].addr, log_q[9].done, log_q[10].hold, W0, W7);
    end
  endtask

  task automatic test_stall;
    test_store("stall", ABC, 32'h1000, '1, 64'b11100);
    for (int r = 2; r <= 5; r++) begin
      vectors++;
      if (log_q[r].req !== 1'b1 || log_q[r].addr !== 32'h1004 || log_q[r].data !== W1) begin
        errs++;
        $display("FAIL stall hold cycle %0d: req %b addr %h data %h, required 1 00001004 %h",
                 r, log_q[r].req, log_q[r].addr, log_q[r].data, W1);
      end
    end
    vectors++;
    if (log_q[12].done !== 1'b1) begin
      errs++;
      $display("FAIL stall done cycle 12: %b, required 1", log_q[12].done);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] want[8] = '{32'hfffffff0, 32'hfffffff4, 32'hfffffff8, 32'hfffffffc, 0, 4, 8, 12};
    test_store("wrap", rand_digest(), 32'hfffffff3, '1, '0);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (log_q[i + 1].addr !== want[i]) begin
        errs++;
        $display("FAIL wrap addr word%0d: %h, required %h", i, log_q[i + 1].addr, want[i]);
      end
    end
  endtask

  task automatic test_held;
    test_store("held", rand_digest(), $urandom, ((64'd1 << 45) - 1) & ~(64'd1 << 20), ((64'd1 << 26) - 1) & ~64'd1);
  endtask

  task automatic test_random;
    logic [63:0] lm;
    repeat (6) begin
      lm = {32'($urandom), 32'($urandom)} & {32'($urandom), 32'($urandom)} & 64'h0000_00ff_ffff_fffe;
      test_store("random", rand_digest(), $urandom, '1, lm);
    end
  endtask

  task automatic test_reset_mid;
    int n = 0, late = 0;
    log_q.delete();
    @(posedge clk); #1;
    t0 = cyc; logging = 1; hash_value = ABC; dst_addr = 32'h2000; save_hash = 1; mem_ready = 1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1; save_hash = 0;
    @(negedge clk);
    vectors++;
    if ({mem_req, mem_we, hold_pipeline, busy, done} !== 5'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errs++;
      $display("FAIL mid reset: req/we/hold/busy/done %b addr %h data %h, required all 0",
               {mem_req, mem_we, hold_pipeline, busy, done}, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    logging = 0;
    foreach (log_q[j]) begin
      if (log_q[j].req && log_q[j].rdy && log_q[j].r < 4) n++;
      if (log_q[j].req && log_q[j].r >= 4) late++;
    end
    vectors++;
    if (n !== 3 || late !== 0) begin
      errs++;
      $display("FAIL mid reset stores: %0d before, %0d after, required 3 before, 0 after", n, late);
    end
    test_store("restart", rand_digest(), 32'h3000, '1, '0);
  endtask

  initial begin
    test_reset;
    test_abc;
    test_stall;
    test_wrap;
    test_held;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
